mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access pipeline stage directly downstream of the execute stage; upstream of writeback.
- Consumes the execute-stage bundle: issued instruction, effective address, store data.
- Performs loads and stores over a single-outstanding req/ack data-memory port, and aligns and extends load data.
- Non-memory instructions pass through in one cycle; memory ops stall upstream until the access completes.

Parameters:
- ADDR_W, 32, data-memory address width.
- XLEN, 32, width of reg_data_t.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset; synchronous, active-low; clock i_clk.
- i_flush  in  1  pipeline flush.
- i_stall  in  1  stall from downstream.
- i_instr  in  issued_instr_t  instruction from execute.
- i_data  in  32  ALU/BRU result, or effective address for UNIT_MEM.
- i_data_rs2  in  32  store data.
- o_stall  out  1  stall to execute.
- o_instr  out  issued_instr_t  instruction to writeback.
- o_data  out  32  result to writeback.
- o_dmem_req  out  1  memory request; held until ack.
- o_dmem_we  out  1  1 = store.
- o_dmem_addr  out  32  word-aligned address ({addr[31:2], 2'b00}).
- o_dmem_wdata  out  32  lane-replicated store data.
- o_dmem_wstrb  out  4  byte enables.
- i_dmem_ack  in  1  one-cycle completion pulse.
- i_dmem_rdata  in  32  load word; valid with ack.

Behaviour:
- Reset: o_instr, o_data, o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata and o_dmem_wstrb are 0; state IDLE.
- mem_op = i_instr.valid & unit==UNIT_MEM & except==`EXCEPT_NONE.
  - Fields used: op.mem (LD/ST), op_size.bytes (1/2/4), op_size.unsigned.
- Misalignment: half with addr[0]!=0, or word with addr[1:0]!=0.
  - No request is issued.
  - Forwarded in 1 cycle as compose_issued_instr(pc, decode, `EXCEPT_MISALIGN, 1'b1), with o_data = address.
- UNIT_AMO: not serviced. Forwarded in 1 cycle with `EXCEPT_ILLEGAL.
- Non-mem, already-excepted, or invalid instruction: when ~i_stall, o_instr <= i_instr and o_data <= i_data.
- Stores:
  - wstrb = byte 0001<<a, half 0011<<a, word 1111, where a = addr[1:0].
  - wdata = rs2 byte replicated x4, half replicated x2, or word.
  - Store o_data = 0.
- Loads: rdata >> (a*8), then take the low 8/16/32 bits, sign- or zero-extended per op_size.unsigned.
- State machine:
  - IDLE: on aligned mem_op & ~i_flush, latch the request registers and go to WAIT. o_stall=1 this cycle.
  - WAIT:
    - o_dmem_req=1; address and data stay stable.
    - If ack & ~i_stall: write result to o_instr/o_data, go to IDLE, o_stall=i_stall.
    - If ack & i_stall: capture the extended load data, go to DONE, o_stall=1.
    - No ack: o_stall=1.
  - DONE: o_stall=i_stall. When ~i_stall: output the held result, go to IDLE.
  - DRAIN: o_dmem_req=1, o_stall=1. On ack: discard, go to IDLE.
- Upstream holds i_instr stable while o_stall=1. The instruction is consumed on the edge where o_stall=0.
- Latency: pass-through 1 cycle. Memory op 1 + N cycles, where N ≥ 1 is the cycle ack arrives after req rises. Minimum 2.
- Flush:
  - o_instr and o_data cleared.
  - IDLE or DONE go to IDLE.
  - WAIT goes to DRAIN without ack, or to IDLE if ack arrives in the same cycle.
  - The memory port is never abandoned mid-access.
- Flush has priority over the downstream stall.
- A mem_op arriving with i_flush=1 is dropped.
- Reset mid-access: go to IDLE immediately and drop req. The memory model is reset on the same i_rst_n.
- At most one outstanding request at any time.

Decomposition:
- Shared package additions:
  - OP_MEM_LD and OP_MEM_ST.
  - op_size.bytes and op_size.unsigned fields.
  - `EXCEPT_MISALIGN and `EXCEPT_ILLEGAL.
  - mem_state_t {IDLE, WAIT, DONE, DRAIN}.
- One sub-module, load_align: combinational (rdata, offset, size, unsigned) -> extended data. Reused later by the AMO unit.
- Store lane and strobe generation stays inline.

Test Plan:
- Pass-through: ALU instr, i_data=0x1234 -> o_data=0x1234 next cycle; o_dmem_req never asserted.
- LW addr 0x100, ack 1 cycle after req, rdata 0xDEADBEEF:
  - o_dmem_addr=0x100, we=0.
  - o_data=0xDEADBEEF 2 cycles after issue.
  - o_stall high exactly 1 cycle.
- LB / LBU addr 0x103, rdata 0x80112233: LB -> 0xFFFFFF80; LBU -> 0x00000080.
- SH addr 0x102, rs2=0x1234ABCD -> wstrb=1100, wdata=0xABCDABCD, we=1, o_data=0.
- Misaligned LW addr 0x101:
  - No req.
  - Next cycle o_instr carries `EXCEPT_MISALIGN, valid=1, o_data=0x101.
- Flush and stall:
  - Flush in WAIT, ack 3 cycles later: DRAIN holds req and o_stall=1 until ack; o_instr stays 0; IDLE after ack.
  - i_stall=1 at ack: DONE holds rdata; it emits on the first ~i_stall cycle.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types for the memory stage: instruction bundle, memory op encodings, FSM states.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
`ifndef MEM_STAGE_EXCEPT_DEFS
`define MEM_STAGE_EXCEPT_DEFS
`define EXCEPT_NONE     2'd0
`define EXCEPT_MISALIGN 2'd1
`define EXCEPT_ILLEGAL  2'd2
`endif

package mem_stage_pkg;

  localparam int REG_W = 32;
  typedef logic [REG_W-1:0] reg_data_t;

  typedef logic [1:0] except_t;

  typedef enum logic [1:0] {
    UNIT_ALU = 2'd0,
    UNIT_BRU = 2'd1,
    UNIT_MEM = 2'd2,
    UNIT_AMO = 2'd3
  } unit_t;

  typedef enum logic {
    OP_MEM_LD = 1'b0,
    OP_MEM_ST = 1'b1
  } op_mem_t;

  typedef struct packed {
    op_mem_t mem;
  } op_t;

  // bytes is 1, 2 or 4; is_unsigned selects zero extension on loads
  typedef struct packed {
    logic [2:0] bytes;
    logic       is_unsigned;
  } op_size_t;

  typedef struct packed {
    unit_t    unit;
    op_t      op;
    op_size_t op_size;
    logic [4:0] rd;
  } decode_t;

  typedef struct packed {
    logic       valid;
    logic [31:0] pc;
    decode_t    decode;
    except_t    except;
  } issued_instr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DONE  = 2'd2,
    DRAIN = 2'd3
  } mem_state_t;

  function automatic issued_instr_t compose_issued_instr(input logic [31:0] pc,
                                                         input decode_t     decode,
                                                         input except_t     exc,
                                                         input logic        valid);
    issued_instr_t r;
    r.valid  = valid;
    r.pc     = pc;
    r.decode = decode;
    r.except = exc;
    return r;
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: shifts the addressed lane down and sign/zero extends it.
// Latency: combinational.
// Backpressure: none; ports rdata_i/offset_i/size_i/unsigned_i in, data_o out.
module mem_stage_load_align (
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata_i >> {offset_i, 3'b000};
    data_o  = shifted;
    case (size_i)
      3'd1:    data_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
      3'd2:    data_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: pass-through for non-memory ops, single-outstanding req/ack loads and stores.
// Latency: 1 cycle pass-through; 1 + N cycles for memory ops (N = req-to-ack cycles, N >= 1).
// Backpressure: o_stall holds execute during an access; i_stall holds results (DONE buffers a load).
// Ports: i_instr/i_data/i_data_rs2 from execute, o_instr/o_data to writeback, o_dmem_* / i_dmem_* to memory.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_stall,
  input  issued_instr_t     i_instr,
  input  logic [XLEN-1:0]   i_data,
  input  logic [XLEN-1:0]   i_data_rs2,
  output logic              o_stall,
  output issued_instr_t     o_instr,
  output logic [XLEN-1:0]   o_data,
  output logic              o_dmem_req,
  output logic              o_dmem_we,
  output logic [ADDR_W-1:0] o_dmem_addr,
  output logic [31:0]       o_dmem_wdata,
  output logic [3:0]        o_dmem_wstrb,
  input  logic              i_dmem_ack,
  input  logic [31:0]       i_dmem_rdata
);

  mem_state_t      state_q, state_d;
  issued_instr_t   instr_q, instr_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [XLEN-1:0] held_q, held_d;
  issued_instr_t   pend_q, pend_d;
  logic            we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic [1:0]      off_q, off_d;
  logic [2:0]      size_q, size_d;
  logic            uns_q, uns_d;

  logic        base_ok, mem_op, amo_op, misalign, is_store;
  logic [1:0]  a;
  logic [2:0]  size;
  logic [3:0]  st_wstrb;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;
  logic [XLEN-1:0] result;

  assign base_ok  = i_instr.valid && (i_instr.except == `EXCEPT_NONE);
  assign mem_op   = base_ok && (i_instr.decode.unit == UNIT_MEM);
  assign amo_op   = base_ok && (i_instr.decode.unit == UNIT_AMO);
  assign a        = i_data[1:0];
  assign size     = i_instr.decode.op_size.bytes;
  assign misalign = ((size == 3'd2) && a[0]) || ((size == 3'd4) && (a != 2'b00));
  assign is_store = (i_instr.decode.op.mem == OP_MEM_ST);

  // Store lanes: narrow data is replicated so any byte enable picks the right value.
  always_comb begin
    st_wstrb = 4'b1111;
    st_wdata = i_data_rs2[31:0];
    case (size)
      3'd1: begin
        st_wstrb = 4'b0001 << a;
        st_wdata = {4{i_data_rs2[7:0]}};
      end
      3'd2: begin
        st_wstrb = 4'b0011 << a;
        st_wdata = {2{i_data_rs2[15:0]}};
      end
      default: ;
    endcase
  end

  mem_stage_load_align u_load_align (
    .rdata_i    (i_dmem_rdata),
    .offset_i   (off_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (ld_data)
  );

  assign result = we_q ? '0 : ld_data;

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    data_d  = data_q;
    held_d  = held_q;
    pend_d  = pend_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    off_d   = off_q;
    size_d  = size_q;
    uns_d   = uns_q;
    o_stall = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_flush) begin
          instr_d = '0;
          data_d  = '0;
        end else if (mem_op && !misalign) begin
          // Launch regardless of i_stall: the result waits in DONE if needed.
          o_stall = 1'b1;
          pend_d  = i_instr;
          we_d    = is_store;
          addr_d  = i_data[ADDR_W-1:0];
          wdata_d = is_store ? st_wdata : '0;
          wstrb_d = is_store ? st_wstrb : 4'b0000;
          off_d   = a;
          size_d  = size;
          uns_d   = i_instr.decode.op_size.is_unsigned;
          state_d = WAIT;
        end else begin
          o_stall = i_stall;
          if (!i_stall) begin
            if (mem_op) begin
              instr_d = compose_issued_instr(i_instr.pc, i_instr.decode, `EXCEPT_MISALIGN, 1'b1);
            end else if (amo_op) begin
              instr_d = compose_issued_instr(i_instr.pc, i_instr.decode, `EXCEPT_ILLEGAL, 1'b1);
            end else begin
              instr_d = i_instr;
            end
            data_d = i_data;
          end
        end
      end
      WAIT: begin
        if (i_dmem_ack) begin
          state_d = IDLE;
          if (i_flush) begin
            instr_d = '0;
            data_d  = '0;
          end else if (i_stall) begin
            o_stall = 1'b1;
            held_d  = result;
            state_d = DONE;
          end else begin
            instr_d = pend_q;
            data_d  = result;
          end
        end else begin
          o_stall = 1'b1;
          if (i_flush) begin
            // Access already in flight: keep req up and swallow the ack.
            instr_d = '0;
            data_d  = '0;
            state_d = DRAIN;
          end
        end
      end
      DONE: begin
        if (i_flush) begin
          instr_d = '0;
          data_d  = '0;
          state_d = IDLE;
        end else begin
          o_stall = i_stall;
          if (!i_stall) begin
            instr_d = pend_q;
            data_d  = held_q;
            state_d = IDLE;
          end
        end
      end
      DRAIN: begin
        o_stall = 1'b1;
        if (i_flush) begin
          instr_d = '0;
          data_d  = '0;
        end
        if (i_dmem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      instr_q <= '0;
      data_q  <= '0;
      held_q  <= '0;
      pend_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      off_q   <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      data_q  <= data_d;
      held_q  <= held_d;
      pend_q  <= pend_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      off_q   <= off_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
    end
  end

  assign o_instr      = instr_q;
  assign o_data       = data_q;
  assign o_dmem_req   = (state_q == WAIT) || (state_q == DRAIN);
  assign o_dmem_we    = we_q;
  assign o_dmem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign o_dmem_wdata = wdata_q;
  assign o_dmem_wstrb = wstrb_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: scoreboard of expected writeback bundles plus a req/ack memory model.
// Latency: n/a.
// Backpressure: drives i_stall / i_flush per scenario.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_flush = 1'b0;
  logic          i_stall = 1'b0;
  issued_instr_t i_instr = '0;
  logic [31:0]   i_data = '0;
  logic [31:0]   i_data_rs2 = '0;
  logic          o_stall;
  issued_instr_t o_instr;
  logic [31:0]   o_data;
  logic          o_dmem_req;
  logic          o_dmem_we;
  logic [31:0]   o_dmem_addr;
  logic [31:0]   o_dmem_wdata;
  logic [3:0]    o_dmem_wstrb;
  logic          i_dmem_ack = 1'b0;
  logic [31:0]   i_dmem_rdata = 32'hA5A5A5A5;

  mem_stage #(.ADDR_W(32), .XLEN(32)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush), .i_stall(i_stall),
    .i_instr(i_instr), .i_data(i_data), .i_data_rs2(i_data_rs2),
    .o_stall(o_stall), .o_instr(o_instr), .o_data(o_data),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
    .o_dmem_wdata(o_dmem_wdata), .o_dmem_wstrb(o_dmem_wstrb),
    .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata)
  );

  initial forever #5 i_clk = ~i_clk;

  typedef struct packed {
    issued_instr_t instr;
    logic [31:0]   data;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // Memory model: acks on the ack_lat-th cycle that req is high; captures the request seen at ack.
  int          ack_lat = 1;
  logic [31:0] mem_word = '0;
  int          req_cycles = 0;
  int          cnt = 0;
  logic        cap_we;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_wstrb;

  initial begin
    forever begin
      @(posedge i_clk); #1;
      i_dmem_ack   = 1'b0;
      i_dmem_rdata = 32'hA5A5A5A5;
      if (!i_rst_n) cnt = 0;
      else if (o_dmem_req) begin
        cnt++;
        req_cycles++;
        if (cnt >= ack_lat) begin
          i_dmem_ack   = 1'b1;
          i_dmem_rdata = mem_word;
          cap_we       = o_dmem_we;
          cap_addr     = o_dmem_addr;
          cap_wdata    = o_dmem_wdata;
          cap_wstrb    = o_dmem_wstrb;
          cnt = 0;
        end
      end else cnt = 0;
    end
  end

  function automatic issued_instr_t mk(input unit_t u, input op_mem_t m, input logic [2:0] b,
                                       input logic uns, input logic [31:0] pc);
    issued_instr_t r;
    r = '0;
    r.valid = 1'b1;
    r.pc = pc;
    r.decode.unit = u;
    r.decode.op.mem = m;
    r.decode.op_size.bytes = b;
    r.decode.op_size.is_unsigned = uns;
    r.decode.rd = 5'd7;
    r.except = `EXCEPT_NONE;
    return r;
  endfunction

  // Presents one instruction, records its expected result, and waits until it is consumed.
  task automatic issue(input issued_instr_t ins, input logic [31:0] d, input logic [31:0] rs2,
                       input issued_instr_t ei, input logic [31:0] ed, output int stalls);
    exp_t e;
    stalls = 0;
    i_instr = ins; i_data = d; i_data_rs2 = rs2;
    e.instr = ei; e.data = ed;
    exp_q.push_back(e);
    for (int k = 0; k < 64; k++) begin
      @(negedge i_clk);
      if (!o_stall) break;
      stalls++;
      @(posedge i_clk); #1;
    end
    @(posedge i_clk); #1;
    i_instr = '0; i_data = '0; i_data_rs2 = '0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_instr = mk(UNIT_MEM, OP_MEM_ST, 3'd4, 1'b0, 32'h40);
    i_data = 32'h100; i_data_rs2 = 32'hFFFFFFFF;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    checks++; if (o_instr !== '0 || o_data !== 32'h0) begin failures++;
      $display("FAIL reset_out instr=%h data=%h exp 0", o_instr, o_data); end
    checks++; if (o_dmem_req !== 1'b0) begin failures++;
      $display("FAIL reset_req got=%b exp 0", o_dmem_req); end
    checks++; if ({o_dmem_we, o_dmem_addr, o_dmem_wdata, o_dmem_wstrb} !== '0) begin failures++;
      $display("FAIL reset_port we=%b addr=%h wdata=%h wstrb=%b exp 0", o_dmem_we, o_dmem_addr, o_dmem_wdata, o_dmem_wstrb); end
    i_instr = '0; i_data = '0; i_data_rs2 = '0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
  endtask

  task automatic test_passthrough();
    issued_instr_t ins;
    exp_t e;
    int st;
    ins = mk(UNIT_ALU, OP_MEM_LD, 3'd4, 1'b0, 32'h200);
    req_cycles = 0;
    issue(ins, 32'h1234, 32'h0, ins, 32'h1234, st);
    e = exp_q.pop_front();
    checks++; if (st !== 0) begin failures++; $display("FAIL pass_stall got=%0d exp 0", st); end
    checks++; if (o_data !== e.data) begin failures++; $display("FAIL pass_data got=%h exp=%h", o_data, e.data); end
    checks++; if (o_instr !== e.instr) begin failures++; $display("FAIL pass_instr got=%h exp=%h", o_instr, e.instr); end
    checks++; if (req_cycles !== 0) begin failures++; $display("FAIL pass_noreq got=%0d exp 0", req_cycles); end
  endtask

  task automatic test_lw();
    issued_instr_t ins;
    exp_t e;
    int st;
    ins = mk(UNIT_MEM, OP_MEM_LD, 3'd4, 1'b0, 32'h204);
    ack_lat = 1; mem_word = 32'hDEADBEEF;
    issue(ins, 32'h100, 32'h0, ins, 32'hDEADBEEF, st);
    e = exp_q.pop_front();
    checks++; if (st !== 1) begin failures++; $display("FAIL lw_stall got=%0d exp 1", st); end
    checks++; if (cap_addr !== 32'h100 || cap_we !== 1'b0) begin failures++;
      $display("FAIL lw_req addr=%h we=%b exp 00000100 0", cap_addr, cap_we); end
    checks++; if (o_data !== e.data) begin failures++; $display("FAIL lw_data got=%h exp=%h", o_data, e.data); end
    checks++; if (o_instr !== e.instr) begin failures++; $display("FAIL lw_instr got=%h exp=%h", o_instr, e.instr); end
    checks++; if (o_dmem_req !== 1'b0) begin failures++; $display("FAIL lw_req_drop got=%b exp 0", o_dmem_req); end
  endtask

  task automatic test_load_extend();
    logic [2:0]  sz[4]  = '{3'd1, 3'd1, 3'd2, 3'd2};
    logic        un[4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] ad[4]  = '{32'h103, 32'h103, 32'h102, 32'h102};
    logic [31:0] ex[4]  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8011, 32'h00008011};
    ack_lat = 2; mem_word = 32'h80112233;
    for (int i = 0; i < 4; i++) begin
      issued_instr_t ins;
      exp_t e;
      int st;
      ins = mk(UNIT_MEM, OP_MEM_LD, sz[i], un[i], 32'h300 + i * 4);
      issue(ins, ad[i], 32'h0, ins, ex[i], st);
      e = exp_q.pop_front();
      checks++; if (o_data !== e.data || o_instr !== e.instr) begin failures++;
        $display("FAIL load_ext%0d data=%h exp=%h instr=%h exp=%h", i, o_data, e.data, o_instr, e.instr); end
      checks++; if (st !== 2) begin failures++; $display("FAIL load_ext%0d_stall got=%0d exp 2", i, st); end
    end
  endtask

  task automatic test_store();
    logic [2:0]  sz[3] = '{3'd2, 3'd1, 3'd4};
    logic [31:0] ad[3] = '{32'h102, 32'h107, 32'h108};
    logic [31:0] rs[3] = '{32'h1234ABCD, 32'h0000005A, 32'h11223344};
    logic [31:0] wa[3] = '{32'h100, 32'h104, 32'h108};
    logic [3:0]  ws[3] = '{4'b1100, 4'b1000, 4'b1111};
    logic [31:0] wd[3] = '{32'hABCDABCD, 32'h5A5A5A5A, 32'h11223344};
    ack_lat = 1; mem_word = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      issued_instr_t ins;
      exp_t e;
      int st;
      ins = mk(UNIT_MEM, OP_MEM_ST, sz[i], 1'b0, 32'h400 + i * 4);
      issue(ins, ad[i], rs[i], ins, 32'h0, st);
      e = exp_q.pop_front();
      checks++; if (cap_wstrb !== ws[i] || cap_wdata !== wd[i]) begin failures++;
        $display("FAIL store%0d_lanes wstrb=%b exp=%b wdata=%h exp=%h", i, cap_wstrb, ws[i], cap_wdata, wd[i]); end
      checks++; if (cap_we !== 1'b1 || cap_addr !== wa[i]) begin failures++;
        $display("FAIL store%0d_req we=%b addr=%h exp 1 %h", i, cap_we, cap_addr, wa[i]); end
      checks++; if (o_data !== e.data || o_instr !== e.instr) begin failures++;
        $display("FAIL store%0d_out data=%h exp=%h instr=%h exp=%h", i, o_data, e.data, o_instr, e.instr); end
    end
  endtask

  task automatic test_misalign();
    logic [2:0]  sz[3] = '{3'd4, 3'd2, 3'd4};
    op_mem_t     op[3] = '{OP_MEM_LD, OP_MEM_LD, OP_MEM_ST};
    logic [31:0] ad[3] = '{32'h101, 32'h103, 32'h102};
    for (int i = 0; i < 3; i++) begin
      issued_instr_t ins, ei;
      exp_t e;
      int st;
      ins = mk(UNIT_MEM, op[i], sz[i], 1'b0, 32'h500 + i * 4);
      ei = ins;
      ei.except = `EXCEPT_MISALIGN;
      req_cycles = 0;
      issue(ins, ad[i], 32'hCAFE, ei, ad[i], st);
      e = exp_q.pop_front();
      checks++; if (req_cycles !== 0 || st !== 0) begin failures++;
        $display("FAIL misalign%0d_noreq req=%0d stall=%0d exp 0 0", i, req_cycles, st); end
      checks++; if (o_instr !== e.instr || o_data !== e.data) begin failures++;
        $display("FAIL misalign%0d_out instr=%h exp=%h data=%h exp=%h", i, o_instr, e.instr, o_data, e.data); end
    end
  endtask

  task automatic test_amo();
    issued_instr_t ins, ei;
    exp_t e;
    int st;
    ins = mk(UNIT_AMO, OP_MEM_LD, 3'd4, 1'b0, 32'h600);
    ei = ins;
    ei.except = `EXCEPT_ILLEGAL;
    req_cycles = 0;
    issue(ins, 32'h400, 32'h1, ei, 32'h400, st);
    e = exp_q.pop_front();
    checks++; if (req_cycles !== 0 || st !== 0) begin failures++;
      $display("FAIL amo_noreq req=%0d stall=%0d exp 0 0", req_cycles, st); end
    checks++; if (o_instr !== e.instr || o_data !== e.data) begin failures++;
      $display("FAIL amo_out instr=%h exp=%h data=%h exp=%h", o_instr, e.instr, o_data, e.data); end
  endtask

  task automatic test_flush();
    int drain;
    int st;
    exp_t e;
    issued_instr_t alu;
    ack_lat = 4; mem_word = 32'h13579BDF;
    i_instr = mk(UNIT_MEM, OP_MEM_LD, 3'd4, 1'b0, 32'h700);
    i_data = 32'h180;
    @(posedge i_clk); #1;
    i_flush = 1'b1;
    @(negedge i_clk);
    checks++; if (o_stall !== 1'b1 || o_dmem_req !== 1'b1) begin failures++;
      $display("FAIL flush_wait stall=%b req=%b exp 1 1", o_stall, o_dmem_req); end
    @(posedge i_clk); #1;
    i_flush = 1'b0;
    i_instr = '0; i_data = '0;
    checks++; if (o_instr !== '0 || o_data !== 32'h0) begin failures++;
      $display("FAIL flush_clear instr=%h data=%h exp 0", o_instr, o_data); end
    drain = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge i_clk);
      if (!o_dmem_req) break;
      drain++;
      checks++; if (o_stall !== 1'b1 || o_instr !== '0) begin failures++;
        $display("FAIL flush_drain stall=%b instr=%h exp 1 0", o_stall, o_instr); end
      @(posedge i_clk); #1;
    end
    checks++; if (drain !== 3) begin failures++; $display("FAIL flush_drain_len got=%0d exp 3", drain); end
    checks++; if (o_instr !== '0 || o_stall !== 1'b0) begin failures++;
      $display("FAIL flush_idle instr=%h stall=%b exp 0 0", o_instr, o_stall); end
    @(posedge i_clk); #1;
    alu = mk(UNIT_BRU, OP_MEM_LD, 3'd4, 1'b0, 32'h704);
    issue(alu, 32'h99, 32'h0, alu, 32'h99, st);
    e = exp_q.pop_front();
    checks++; if (st !== 0 || o_data !== e.data || o_instr !== e.instr) begin failures++;
      $display("FAIL flush_after stall=%0d data=%h exp=%h", st, o_data, e.data); end
  endtask

  task automatic test_stall_done();
    issued_instr_t alu, ld;
    exp_t e;
    int st;
    alu = mk(UNIT_ALU, OP_MEM_LD, 3'd4, 1'b0, 32'h800);
    issue(alu, 32'h55, 32'h0, alu, 32'h55, st);
    e = exp_q.pop_front();
    checks++; if (o_data !== e.data) begin failures++; $display("FAIL stall_pre got=%h exp=%h", o_data, e.data); end
    ack_lat = 2; mem_word = 32'h0BADF00D;
    ld = mk(UNIT_MEM, OP_MEM_LD, 3'd4, 1'b0, 32'h804);
    e.instr = ld; e.data = 32'h0BADF00D;
    exp_q.push_back(e);
    i_instr = ld; i_data = 32'h200;
    @(posedge i_clk); #1;
    i_stall = 1'b1;
    @(posedge i_clk); #1;
    @(negedge i_clk);
    checks++; if (i_dmem_ack !== 1'b1 || o_stall !== 1'b1) begin failures++;
      $display("FAIL stall_ack ack=%b stall=%b exp 1 1", i_dmem_ack, o_stall); end
    @(posedge i_clk); #1;
    for (int k = 0; k < 2; k++) begin
      @(negedge i_clk);
      checks++; if (o_stall !== 1'b1 || o_dmem_req !== 1'b0 || o_data !== 32'h55) begin failures++;
        $display("FAIL stall_done%0d stall=%b req=%b data=%h exp 1 0 00000055", k, o_stall, o_dmem_req, o_data); end
      @(posedge i_clk); #1;
    end
    i_stall = 1'b0;
    @(negedge i_clk);
    checks++; if (o_stall !== 1'b0) begin failures++; $display("FAIL stall_release got=%b exp 0", o_stall); end
    @(posedge i_clk); #1;
    i_instr = '0; i_data = '0;
    e = exp_q.pop_front();
    checks++; if (o_data !== e.data || o_instr !== e.instr) begin failures++;
      $display("FAIL stall_emit data=%h exp=%h instr=%h exp=%h", o_data, e.data, o_instr, e.instr); end
  endtask

  task automatic test_reset_mid();
    issued_instr_t ld;
    exp_t e;
    int st;
    ack_lat = 5;
    i_instr = mk(UNIT_MEM, OP_MEM_LD, 3'd4, 1'b0, 32'h900);
    i_data = 32'h240;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_rst_n = 1'b0;
    i_instr = '0; i_data = '0;
    @(posedge i_clk); #1;
    checks++; if (o_dmem_req !== 1'b0 || o_instr !== '0 || o_data !== 32'h0) begin failures++;
      $display("FAIL rstmid req=%b instr=%h data=%h exp 0", o_dmem_req, o_instr, o_data); end
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    ack_lat = 1; mem_word = 32'h12345678;
    ld = mk(UNIT_MEM, OP_MEM_LD, 3'd4, 1'b0, 32'h904);
    issue(ld, 32'h300, 32'h0, ld, 32'h12345678, st);
    e = exp_q.pop_front();
    checks++; if (st !== 1 || o_data !== e.data || cap_addr !== 32'h300) begin failures++;
      $display("FAIL rstmid_after stall=%0d data=%h exp=%h addr=%h", st, o_data, e.data, cap_addr); end
  endtask

  task automatic test_back_to_back();
    issued_instr_t lw, sb, alu;
    exp_t e;
    int st0, st1, st2;
    ack_lat = 3; mem_word = 32'hCAFEF00D;
    lw  = mk(UNIT_MEM, OP_MEM_LD, 3'd4, 1'b0, 32'hA00);
    sb  = mk(UNIT_MEM, OP_MEM_ST, 3'd1, 1'b0, 32'hA04);
    alu = mk(UNIT_ALU, OP_MEM_LD, 3'd4, 1'b0, 32'hA08);
    issue(lw, 32'h104, 32'h0, lw, 32'hCAFEF00D, st0);
    e = exp_q.pop_front();
    checks++; if (st0 !== 3 || o_data !== e.data || o_instr !== e.instr) begin failures++;
      $display("FAIL b2b_lw stall=%0d exp 3 data=%h exp=%h", st0, o_data, e.data); end
    issue(sb, 32'h107, 32'h0000005A, sb, 32'h0, st1);
    e = exp_q.pop_front();
    checks++; if (st1 !== 3 || o_data !== e.data || o_instr !== e.instr) begin failures++;
      $display("FAIL b2b_sb stall=%0d exp 3 data=%h exp=%h", st1, o_data, e.data); end
    checks++; if (cap_wstrb !== 4'b1000 || cap_wdata !== 32'h5A5A5A5A || cap_addr !== 32'h104) begin failures++;
      $display("FAIL b2b_sb_req wstrb=%b wdata=%h addr=%h exp 1000 5a5a5a5a 00000104", cap_wstrb, cap_wdata, cap_addr); end
    issue(alu, 32'h77, 32'h0, alu, 32'h77, st2);
    e = exp_q.pop_front();
    checks++; if (st2 !== 0 || o_data !== e.data || o_instr !== e.instr) begin failures++;
      $display("FAIL b2b_alu stall=%0d exp 0 data=%h exp=%h", st2, o_data, e.data); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_lw();
    test_load_extend();
    test_store();
    test_misalign();
    test_amo();
    test_flush();
    test_stall_done();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
